// File: rtl/emesh_rr_arbiter.sv
// Three-way round-robin arbiter merging cmesh/rmesh/xmesh packets into one
// registered emesh output stage with valid/ready flow control.
module emesh_rr_arbiter #(
    parameter int AW = 32,
    parameter int PW = 2*AW+40
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          cmesh_access_in,
    input  logic [PW-1:0] cmesh_packet_in,
    output logic          cmesh_ready_out,
    input  logic          rmesh_access_in,
    input  logic [PW-1:0] rmesh_packet_in,
    output logic          rmesh_ready_out,
    input  logic          xmesh_access_in,
    input  logic [PW-1:0] xmesh_packet_in,
    output logic          xmesh_ready_out,
    output logic          emesh_access_out,
    output logic [PW-1:0] emesh_packet_out,
    input  logic          emesh_ready_in,
    output logic [1:0]    arb_state_out
);

    // Handshake: a transfer happens on a rising edge where valid (access) and
    // ready are both high; ready never depends on the packet contents.

    // Priority pointer names the port searched first.
    localparam logic [1:0] PC = 2'd0;
    localparam logic [1:0] PR = 2'd1;
    localparam logic [1:0] PX = 2'd2;

    logic [1:0]    ptr_q, ptr_d;
    logic          access_q, access_d;
    logic [PW-1:0] packet_q, packet_d;
    logic          can_accept;
    logic [2:0]    grant;   // {x, r, c}

    assign can_accept = ~access_q | emesh_ready_in;

    always_comb begin
        grant = 3'b000;
        case (ptr_q)
            PR: begin
                if (rmesh_access_in)      grant = 3'b010;
                else if (xmesh_access_in) grant = 3'b100;
                else if (cmesh_access_in) grant = 3'b001;
            end
            PX: begin
                if (xmesh_access_in)      grant = 3'b100;
                else if (cmesh_access_in) grant = 3'b001;
                else if (rmesh_access_in) grant = 3'b010;
            end
            default: begin
                if (cmesh_access_in)      grant = 3'b001;
                else if (rmesh_access_in) grant = 3'b010;
                else if (xmesh_access_in) grant = 3'b100;
            end
        endcase
    end

    assign cmesh_ready_out = grant[0] & can_accept & nreset;
    assign rmesh_ready_out = grant[1] & can_accept & nreset;
    assign xmesh_ready_out = grant[2] & can_accept & nreset;

    // While stalled everything holds; otherwise the served port drops to
    // lowest priority and its packet is captured.
    always_comb begin
        ptr_d    = ptr_q;
        access_d = access_q;
        packet_d = packet_q;
        if (can_accept) begin
            access_d = |grant;
            if (grant[0]) begin
                packet_d = cmesh_packet_in;
                ptr_d    = PR;
            end else if (grant[1]) begin
                packet_d = rmesh_packet_in;
                ptr_d    = PX;
            end else if (grant[2]) begin
                packet_d = xmesh_packet_in;
                ptr_d    = PC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            ptr_q    <= PC;
            access_q <= 1'b0;
            packet_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            access_q <= access_d;
            packet_q <= packet_d;
        end
    end

    assign emesh_access_out = access_q;
    assign emesh_packet_out = packet_q;
    assign arb_state_out    = ptr_q;

endmodule
